// File: rtl/binary_to_gray_counter_if.sv
// Control and status bundle for the binary/Gray up-down counter.
// The bench drives through master; the counter sees the same wires through slave.
interface binary_to_gray_counter_if #(
  parameter int WIDTH = 4
);
  // Level signals with no handshake: the counter samples en, up_dn, load and
  // load_bin on every rising clk edge; binary, gray, wrap and step_err are
  // registered and valid for the whole cycle that follows the edge.
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             step_err;

  modport master (
    output en, up_dn, load, load_bin,
    input  binary, gray, wrap, step_err
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output binary, gray, wrap, step_err
  );
endinterface

// File: rtl/binary_to_gray_counter.sv
// Up/down binary counter with a registered Gray mirror, a roll-over pulse and
// a sticky flag that trips if a counting edge moves the Gray code by other than one bit.
module binary_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  binary_to_gray_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] gray_q,   gray_d;
  logic             wrap_q,   wrap_d;
  logic             step_err_q, step_err_d;

  logic             count_edge;
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit_step;

  assign count_edge = !bus.load && bus.en;

  always_comb begin
    binary_d = binary_q;
    if (bus.load) begin
      binary_d = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) binary_d = binary_q + ONE;
      else           binary_d = binary_q - ONE;
    end
  end

  // Gray is derived from the next binary value so both registers load together.
  assign gray_d = binary_d ^ (binary_d >> 1);

  assign gray_diff    = gray_d ^ gray_q;
  assign one_bit_step = (gray_diff != ZERO) && ((gray_diff & (gray_diff - ONE)) == ZERO);

  always_comb begin
    wrap_d     = 1'b0;
    step_err_d = step_err_q;
    if (count_edge) begin
      wrap_d = bus.up_dn ? (binary_q == ONES) : (binary_q == ZERO);
      if (!one_bit_step) step_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_q   <= '0;
      gray_q     <= '0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      binary_q   <= binary_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
    end
  end

  assign bus.binary   = binary_q;
  assign bus.gray     = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.step_err = step_err_q;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Directed bench for binary_to_gray_counter (WIDTH=4) with hand-computed expectations.
module tb_binary_to_gray_counter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  binary_to_gray_counter_if #(.WIDTH(WIDTH)) bus ();

  binary_to_gray_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic up_dn, input logic load,
                       input logic [WIDTH-1:0] load_bin);
    bus.en       = en;
    bus.up_dn    = up_dn;
    bus.load     = load;
    bus.load_bin = load_bin;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 4'b1011);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL reset_binary: got %b expected 0000", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0000) begin n_err++; $display("FAIL reset_gray: got %b expected 0000", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL reset_step_err: got %b expected 0", bus.step_err); end
    // edges under reset must not move the count even with load/en asserted
    tick();
    tick();
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL reset_hold_binary: got %b expected 0000", bus.binary); end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL reset_release_binary: got %b expected 0000", bus.binary); end
  endtask

  task automatic test_up_count();
    logic [WIDTH-1:0] exp_gray [16];
    logic [WIDTH-1:0] exp_bin;
    logic             exp_wrap;
    exp_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_bin  = 4'(i + 1);
      exp_wrap = (i == 15);
      n_cmp++; if (bus.binary !== exp_bin) begin n_err++; $display("FAIL up_binary[%0d]: got %b expected %b", i, bus.binary, exp_bin); end
      n_cmp++; if (bus.gray !== exp_gray[i]) begin n_err++; $display("FAIL up_gray[%0d]: got %b expected %b", i, bus.gray, exp_gray[i]); end
      n_cmp++; if (bus.wrap !== exp_wrap) begin n_err++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, bus.wrap, exp_wrap); end
      n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL up_step_err[%0d]: got %b expected 0", i, bus.step_err); end
    end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    tick();
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL up_wrap_drop: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL up_idle_binary: got %b expected 0000", bus.binary); end
  endtask

  task automatic test_down_count();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    n_cmp++; if (bus.binary !== 4'b1111) begin n_err++; $display("FAIL down1_binary: got %b expected 1111", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b1000) begin n_err++; $display("FAIL down1_gray: got %b expected 1000", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL down1_wrap: got %b expected 1", bus.wrap); end
    tick();
    n_cmp++; if (bus.binary !== 4'b1110) begin n_err++; $display("FAIL down2_binary: got %b expected 1110", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b1001) begin n_err++; $display("FAIL down2_gray: got %b expected 1001", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL down2_wrap: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL down_step_err: got %b expected 0", bus.step_err); end
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b0, 1'b1, 4'b0110);
    tick();
    n_cmp++; if (bus.binary !== 4'b0110) begin n_err++; $display("FAIL ldpri_binary: got %b expected 0110", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0101) begin n_err++; $display("FAIL ldpri_gray: got %b expected 0101", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL ldpri_wrap: got %b expected 0", bus.wrap); end
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    n_cmp++; if (bus.binary !== 4'b0111) begin n_err++; $display("FAIL ldpri_next_binary: got %b expected 0111", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0100) begin n_err++; $display("FAIL ldpri_next_gray: got %b expected 0100", bus.gray); end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_load_boundary();
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    tick();
    n_cmp++; if (bus.binary !== 4'b1111) begin n_err++; $display("FAIL ldb_binary: got %b expected 1111", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b1000) begin n_err++; $display("FAIL ldb_gray: got %b expected 1000", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL ldb_wrap: got %b expected 0", bus.wrap); end
    // load while an up-count would roll over: load wins, no wrap
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    tick();
    n_cmp++; if (bus.binary !== 4'b1111) begin n_err++; $display("FAIL ldwin_binary: got %b expected 1111", bus.binary); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL ldwin_wrap: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL ldwin_step_err: got %b expected 0", bus.step_err); end
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL ldb_up_binary: got %b expected 0000", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0000) begin n_err++; $display("FAIL ldb_up_gray: got %b expected 0000", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL ldb_up_wrap: got %b expected 1", bus.wrap); end
    // load of zero followed by a load edge with down pending must not wrap either
    drive(1'b1, 1'b0, 1'b1, 4'b0000);
    tick();
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL ldzero_wrap: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL ldzero_binary: got %b expected 0000", bus.binary); end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_hold_flip();
    logic [WIDTH-1:0] exp_bin  [3];
    logic [WIDTH-1:0] exp_gray [3];
    exp_bin  = '{4'b0110, 4'b0101, 4'b0110};
    exp_gray = '{4'b0101, 4'b0111, 4'b0101};
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.binary !== 4'b0101) begin n_err++; $display("FAIL hold_binary[%0d]: got %b expected 0101", i, bus.binary); end
      n_cmp++; if (bus.gray !== 4'b0111) begin n_err++; $display("FAIL hold_gray[%0d]: got %b expected 0111", i, bus.gray); end
      n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap[%0d]: got %b expected 0", i, bus.wrap); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i % 2 == 0), 1'b0, 4'b0000);
      tick();
      n_cmp++; if (bus.binary !== exp_bin[i]) begin n_err++; $display("FAIL flip_binary[%0d]: got %b expected %b", i, bus.binary, exp_bin[i]); end
      n_cmp++; if (bus.gray !== exp_gray[i]) begin n_err++; $display("FAIL flip_gray[%0d]: got %b expected %b", i, bus.gray, exp_gray[i]); end
      n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL flip_step_err[%0d]: got %b expected 0", i, bus.step_err); end
    end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 4'b1010);
    tick();
    n_cmp++; if (bus.binary !== 4'b1010) begin n_err++; $display("FAIL ar_pre_binary: got %b expected 1010", bus.binary); end
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL ar_binary: got %b expected 0000", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0000) begin n_err++; $display("FAIL ar_gray: got %b expected 0000", bus.gray); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL ar_wrap: got %b expected 0", bus.wrap); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_err++; $display("FAIL ar_step_err: got %b expected 0", bus.step_err); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.binary !== 4'b0000) begin n_err++; $display("FAIL ar_release_binary: got %b expected 0000", bus.binary); end
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    n_cmp++; if (bus.binary !== 4'b0001) begin n_err++; $display("FAIL ar_first_count: got %b expected 0001", bus.binary); end
    n_cmp++; if (bus.gray !== 4'b0001) begin n_err++; $display("FAIL ar_first_gray: got %b expected 0001", bus.gray); end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    #2;
    test_reset();
    test_up_count();
    test_down_count();
    test_load_priority();
    test_load_boundary();
    test_hold_flip();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binary_to_gray_counter.md
BINARY_TO_GRAY_COUNTER -- requirements
Module: binary_to_gray_counter

Interface
REQ-001 The module SHALL have parameter WIDTH: default 4, count/code width in bits, legal range 2..16.
REQ-002 The module SHALL have port clk: input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port en: input, 1 bit, count enable.
REQ-005 The module SHALL have port up_dn: input, 1 bit, direction (1 = increment, 0 = decrement), sampled only when counting.
REQ-006 The module SHALL have port load: input, 1 bit, synchronous load strobe.
REQ-007 The module SHALL have port load_bin: input, WIDTH bits, binary value to load.
REQ-008 The module SHALL have port binary: output, WIDTH bits, registered binary count.
REQ-009 The module SHALL have port gray: output, WIDTH bits, registered Gray encoding of binary.
REQ-010 The module SHALL have port wrap: output, 1 bit, registered one-cycle pulse on count roll-over.
REQ-011 The module SHALL have port step_err: output, 1 bit, sticky self-check flag.

Function
REQ-012 The module SHALL hold a WIDTH-bit binary count register, updated only on rising clk edges while rst_n is high.
REQ-013 The module SHALL apply priority load > en > hold to each clock edge.
REQ-014 With load=1, the module SHALL set binary to load_bin on the next edge, regardless of en and up_dn.
REQ-015 With load=0, en=1, up_dn=1, the module SHALL set binary to binary+1 modulo 2^WIDTH.
REQ-016 With load=0, en=1, up_dn=0, the module SHALL set binary to binary-1 modulo 2^WIDTH.
REQ-017 With load=0 and en=0, the module SHALL hold binary, gray and step_err, and SHALL drive wrap to 0.
REQ-018 The module SHALL register gray in the same edge as binary, with gray[WIDTH-1] = b[WIDTH-1] and gray[i] = b[i+1] XOR b[i] for i < WIDTH-1, where b is the new binary value, so that gray and binary never disagree in any cycle.
REQ-019 The module SHALL have zero latency from a counting edge to the updated binary and gray outputs; both become visible at the same edge.
REQ-020 The module SHALL assert wrap for exactly one cycle after a counting edge that moves binary from all-ones to zero (up) or from zero to all-ones (down); wrap SHALL be 0 after every other edge.
REQ-021 The module SHALL NOT assert wrap on a load, even when the load value equals zero or all-ones.
REQ-022 The module SHALL set step_err to 1, and keep it set until reset, if a counting edge changes anything other than exactly one bit of gray.
REQ-023 The module SHALL NOT check step_err on load edges.
REQ-024 A direction change between consecutive counting edges SHALL take effect immediately, with no idle cycle.
REQ-025 Simultaneous load=1 and a pending wrap condition SHALL resolve to load behaviour: the value is loaded and wrap is 0.

Reset
REQ-026 While rst_n=0, the module SHALL drive binary=0, gray=0, wrap=0 and step_err=0 asynchronously, independent of clk.
REQ-027 Reset asserted mid-count SHALL discard the in-progress update, with no partial state kept.
REQ-028 After rst_n rises, the first edge SHALL obey REQ-013 to REQ-016 normally.
REQ-029 Inputs sampled at the edge coincident with reset release are not guaranteed to take effect; the bench SHALL hold en=0 and load=0 for that edge.

Verification
REQ-030 Bench SHALL cover full up-count: reset, en=1, up_dn=1 for 16 cycles (WIDTH=4) -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only in the cycle after 1000->0000; step_err stays 0.
REQ-031 Bench SHALL cover down-count from zero: reset, en=1, up_dn=0 for one cycle -> binary=1111, gray=1000, wrap=1 for one cycle; a second step -> binary=1110, gray=1001, wrap=0.
REQ-032 Bench SHALL cover load priority: load=1, load_bin=0110, en=1 -> binary=0110, gray=0101, wrap=0; then load=0, en=1, up_dn=1 -> binary=0111, gray=0100.
REQ-033 Bench SHALL cover load-to-boundary: load_bin=1111 with load=1 -> wrap=0; next up-count -> binary=0000, gray=0000, wrap=1.
REQ-034 Bench SHALL cover hold and direction flip: at binary=0101, en=0 for 3 cycles -> outputs unchanged, wrap=0; then en=1 with up_dn toggling each cycle -> binary alternates 0110,0101,0110, step_err=0.
REQ-035 Bench SHALL cover asynchronous reset mid-count: assert rst_n=0 between clk edges at binary=1010 -> binary=0000, gray=0000, wrap=0, step_err=0 before the next rising edge.
